// File: rtl/pipe_rca_pkg.sv
// Shared constants, helpers and the default-width stage record for pipe_rca_adder.
// The signed-overflow flag is enabled with the PIPE_RCA_OVF_EN macro.
package pipe_rca_pkg;

  localparam int unsigned DefWidth = 32;
  localparam int unsigned DefSeg   = 8;

  function automatic int unsigned calc_stages(int unsigned width, int unsigned seg);
    if (seg == 0 || width < seg) return 1;
    return width / seg;
  endfunction

  // Returns {cout, sum} of a single full-adder bit cell.
  function automatic logic [1:0] full_add(logic a, logic b, logic cin);
    logic s;
    logic c;
    s = a ^ b ^ cin;
    c = (a & b) | (cin & (a ^ b));
    return {c, s};
  endfunction

  // Stage record at the default width; the adder declares the same layout at its own WIDTH.
  typedef struct packed {
    logic                valid;
    logic                carry;
`ifdef PIPE_RCA_OVF_EN
    logic                a_sign;
    logic                b_sign;
`endif
    logic [DefWidth-1:0] sum;
    logic [DefWidth-1:0] a;
    logic [DefWidth-1:0] b;
  } stage_t;

endpackage

// File: rtl/rca_slice.sv
// Combinational SEG-bit ripple-carry adder built from full-adder bit cells.
module rca_slice
  import pipe_rca_pkg::*;
#(
  parameter int unsigned SEG = DefSeg
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           cin,
  output logic [SEG-1:0] sum,
  output logic           cout
);

  always_comb begin
    logic       carry;
    logic [1:0] fa;
    sum   = '0;
    carry = cin;
    for (int unsigned i = 0; i < SEG; i++) begin
      fa     = full_add(a[i], b[i], carry);
      sum[i] = fa[0];
      carry  = fa[1];
    end
    cout = carry;
  end

endmodule

// File: rtl/pipe_rca_adder.sv
// Pipelined WIDTH-bit ripple-carry adder, one SEG-bit slice resolved per stage, valid/ready flow.
// Define PIPE_RCA_OVF_EN to add the out_ovf signed-overflow output.
module pipe_rca_adder
  import pipe_rca_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned SEG   = DefSeg
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
`ifdef PIPE_RCA_OVF_EN
  output logic             out_ovf,
`endif
  output logic             out_cout
);

  localparam int unsigned STAGES = calc_stages(WIDTH, SEG);

  if (SEG < 1) begin : g_bad_seg
    $fatal(1, "pipe_rca_adder: SEG must be at least 1");
  end else if (WIDTH % SEG != 0) begin : g_bad_width
    $fatal(1, "pipe_rca_adder: WIDTH must be a multiple of SEG");
  end

  typedef struct packed {
    logic             valid;
    logic             carry;
`ifdef PIPE_RCA_OVF_EN
    logic             a_sign;
    logic             b_sign;
`endif
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } rec_t;

  rec_t           in_rec;
  rec_t           src       [STAGES];
  rec_t           st_d      [STAGES];
  rec_t           st_q      [STAGES];
  logic [SEG-1:0] slice_sum [STAGES];
  logic           slice_cout[STAGES];
  logic           adv;

  always_comb begin
    in_rec       = '0;
    in_rec.valid = in_valid;
    in_rec.carry = in_cin;
    in_rec.a     = in_a;
    in_rec.b     = in_b;
`ifdef PIPE_RCA_OVF_EN
    in_rec.a_sign = in_a[WIDTH-1];
    in_rec.b_sign = in_b[WIDTH-1];
`endif
  end

  always_comb begin
    src[0] = in_rec;
    for (int unsigned k = 1; k < STAGES; k++) begin
      src[k] = st_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    rca_slice #(
      .SEG(SEG)
    ) u_slice (
      .a   (src[k].a[k*SEG +: SEG]),
      .b   (src[k].b[k*SEG +: SEG]),
      .cin (src[k].carry),
      .sum (slice_sum[k]),
      .cout(slice_cout[k])
    );
  end

  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      st_d[k]                    = src[k];
      st_d[k].sum[k*SEG +: SEG]  = slice_sum[k];
      st_d[k].carry              = slice_cout[k];
    end
  end

  // The whole pipe moves as one; only a stalled full output stage blocks it.
  assign adv      = !st_q[STAGES-1].valid || out_ready;
  assign in_ready = adv;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        st_q[k] <= '0;
      end
    end else if (adv) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        st_q[k] <= st_d[k];
      end
    end
  end

  always_comb begin
    out_valid = st_q[STAGES-1].valid;
    out_sum   = st_q[STAGES-1].sum;
    out_cout  = st_q[STAGES-1].carry;
`ifdef PIPE_RCA_OVF_EN
    out_ovf   = (st_q[STAGES-1].a_sign == st_q[STAGES-1].b_sign) &&
                (st_q[STAGES-1].sum[WIDTH-1] != st_q[STAGES-1].a_sign);
`endif
  end

endmodule

// File: tb/tb_pipe_rca_adder.sv
// Self-checking bench for pipe_rca_adder against an arithmetic reference model.
// Overflow checks are included when PIPE_RCA_OVF_EN is defined.
module tb_pipe_rca_adder;

  localparam int W = 32;
  localparam int G = 8;
  localparam int S = W / G;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         in_cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_sum;
  logic         out_cout;
`ifdef PIPE_RCA_OVF_EN
  logic         out_ovf;
`endif

  int checks = 0;
  int errors = 0;

  // {ovf, cout, sum} expected per accepted pair, in acceptance order.
  logic [W+1:0] exp_q[$];

  pipe_rca_adder #(
    .WIDTH(W),
    .SEG  (G)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_cin   (in_cin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sum  (out_sum),
`ifdef PIPE_RCA_OVF_EN
    .out_ovf  (out_ovf),
`endif
    .out_cout (out_cout)
  );

  always #5 clk = ~clk;

  function automatic logic [W+1:0] model(logic [W-1:0] a, logic [W-1:0] b, logic cin);
    logic [W:0] full;
    logic       ovf;
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    ovf  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
    return {ovf, full};
  endfunction

  task automatic test_reset;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
    if (out_sum !== '0) begin errors++; $display("FAIL reset_out_sum got %h exp 0", out_sum); end
    if (out_cout !== 1'b0) begin errors++; $display("FAIL reset_out_cout got %b exp 0", out_cout); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_single_pairs;
    logic [W-1:0] ta[8];
    logic [W-1:0] tb_v[8];
    logic         tc[8];
    logic [W+1:0] e;
    ta[0] = 32'h0000_0003; tb_v[0] = 32'h0000_0001; tc[0] = 1'b0;
    ta[1] = 32'hFFFF_FFFF; tb_v[1] = 32'h0000_0001; tc[1] = 1'b0;
    ta[2] = 32'h7FFF_FFFF; tb_v[2] = 32'h0000_0001; tc[2] = 1'b0;
    ta[3] = 32'hFFFF_FFFF; tb_v[3] = 32'hFFFF_FFFF; tc[3] = 1'b1;
    for (int i = 4; i < 8; i++) begin
      ta[i] = $urandom; tb_v[i] = $urandom; tc[i] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_a      = ta[i];
      in_b      = tb_v[i];
      in_cin    = tc[i];
      e         = model(ta[i], tb_v[i], tc[i]);
      for (int j = 1; j <= S; j++) begin
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (out_valid !== (j == S)) begin
          errors++;
          $display("FAIL latency_valid pair %0d cycle %0d got %b exp %b", i, j, out_valid, j == S);
        end
      end
      checks += 2;
      if (out_sum !== e[W-1:0]) begin
        errors++; $display("FAIL single_sum pair %0d got %h exp %h", i, out_sum, e[W-1:0]);
      end
      if (out_cout !== e[W]) begin
        errors++; $display("FAIL single_cout pair %0d got %b exp %b", i, out_cout, e[W]);
      end
`ifdef PIPE_RCA_OVF_EN
      checks++;
      if (out_ovf !== e[W+1]) begin
        errors++; $display("FAIL single_ovf pair %0d got %b exp %b", i, out_ovf, e[W+1]);
      end
`endif
    end
  endtask

  task automatic test_back_to_back;
    localparam int N = 16;
    logic [W+1:0] e;
    exp_q.delete();
    for (int j = 0; j < N + S + 1; j++) begin
      @(negedge clk);
      out_ready = 1'b1;
      #1;
      checks++;
      if (out_valid !== (j >= S && j < N + S)) begin
        errors++;
        $display("FAIL b2b_valid cycle %0d got %b exp %b", j, out_valid, j >= S && j < N + S);
      end
      if (out_valid === 1'b1 && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({out_cout, out_sum} !== e[W:0]) begin
          errors++; $display("FAIL b2b_result cycle %0d got %h exp %h", j, {out_cout, out_sum}, e[W:0]);
        end
      end
      if (j < N) begin
        in_valid = 1'b1;
        in_a     = $urandom;
        in_b     = $urandom;
        in_cin   = 1'($urandom_range(0, 1));
        exp_q.push_back(model(in_a, in_b, in_cin));
      end else begin
        in_valid = 1'b0;
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL b2b_leftover got %0d exp 0", exp_q.size());
    end
  endtask

  task automatic test_backpressure;
    localparam int N = 12;
    int           sent = 0;
    int           got = 0;
    int           cyc = 0;
    logic         need_new = 1'b1;
    logic         pv = 1'b0;
    logic         pr = 1'b1;
    logic [W-1:0] psum = '0;
    logic         pcout = 1'b0;
    logic [W+1:0] e;
    exp_q.delete();
    while (got < N && cyc < 200) begin
      @(negedge clk);
      out_ready = !(cyc >= S + 2 && cyc < S + 7);
      if (sent < N) begin
        in_valid = 1'b1;
        if (need_new) begin
          in_a     = $urandom;
          in_b     = $urandom;
          in_cin   = 1'($urandom_range(0, 1));
          need_new = 1'b0;
        end
      end else begin
        in_valid = 1'b0;
      end
      #1;
      checks++;
      if (in_ready !== (!out_valid || out_ready)) begin
        errors++; $display("FAIL bp_in_ready cycle %0d got %b exp %b", cyc, in_ready, !out_valid || out_ready);
      end
      if (pv && !pr) begin
        checks++;
        if (out_valid !== 1'b1 || out_sum !== psum || out_cout !== pcout) begin
          errors++;
          $display("FAIL bp_hold cycle %0d got %b/%h/%b exp 1/%h/%b", cyc, out_valid, out_sum, out_cout, psum, pcout);
        end
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra cycle %0d got %h exp none", cyc, out_sum);
        end else begin
          e = exp_q.pop_front();
          if ({out_cout, out_sum} !== e[W:0]) begin
            errors++; $display("FAIL bp_result cycle %0d got %h exp %h", cyc, {out_cout, out_sum}, e[W:0]);
          end
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_a, in_b, in_cin));
        sent++;
        need_new = 1'b1;
      end
      pv    = out_valid;
      pr    = out_ready;
      psum  = out_sum;
      pcout = out_cout;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    checks++;
    if (got != N) begin
      errors++; $display("FAIL bp_drain got %0d exp %0d", got, N);
    end
  endtask

  task automatic test_reset_midflight;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_a      = $urandom;
      in_b      = $urandom;
      in_cin    = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b exp 0", out_valid); end
    if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_in_ready got %b exp 1", in_ready); end
    if (out_sum !== '0) begin errors++; $display("FAIL midrst_sum got %h exp 0", out_sum); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int j = 0; j < S + 3; j++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++; $display("FAIL midrst_ghost cycle %0d got %b exp 0", j, out_valid);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_pairs();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
